// File: rtl/periph_cmd_master.sv
// Initiator for the peripheral command bus: queues (cmd, word) pairs from the core
// and issues each one with a four-phase request/response handshake and per-phase timeout.
module periph_cmd_master #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [15:0] CMD_READ = 16'h1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cmd_in,
  input  logic [15:0] word_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        request,
  output logic [15:0] cmd,
  output logic [15:0] word,
  input  logic        response,
  input  logic [15:0] keycode,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clear
);

  // Handshake contract: a command is accepted on any posedge where cmd_valid and
  // cmd_ready are both high; the responder sees cmd/word valid whenever request=1
  // and answers with a response pulse, after which request stays low >= 1 full cycle.

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_d;
  logic          push, pop;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          request_d;
  logic [15:0]   cmd_d, word_d, rd_data_d;
  logic          rd_valid_d;
  logic          timeout_hit;
  logic          busy_d;

  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == IDLE) && (count != '0);

  always_comb begin
    count_d = count;
    if (push && !pop) begin
      count_d = count + 1'b1;
    end else if (pop && !push) begin
      count_d = count - 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    request_d   = request;
    cmd_d       = cmd;
    word_d      = word;
    rd_data_d   = rd_data;
    rd_valid_d  = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          {cmd_d, word_d} = mem[rd_ptr];
          request_d       = 1'b1;
          cnt_d           = '0;
          state_d         = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // The responder pulses response for a single cycle, so act on the first sample.
        if (response) begin
          request_d = 1'b0;
          cnt_d     = '0;
          state_d   = WAIT_REL;
          if (cmd == CMD_READ) begin
            rd_data_d  = keycode;
            rd_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          request_d   = 1'b0;
          timeout_hit = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT_REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!response) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_d = (count_d != '0) || (state_d != IDLE);

  // Storage needs no reset: occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_in, word_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      request     <= 1'b0;
      cmd         <= '0;
      word        <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      request  <= request_d;
      cmd      <= cmd_d;
      word     <= word_d;
      rd_data  <= rd_data_d;
      rd_valid <= rd_valid_d;
      busy     <= busy_d;
      count    <= count_d;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clear) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
